// File: rtl/fb_ifetch_pkg.sv
// fb_ifetch_pkg
//   Shared definitions for the instruction-fetch front end: data width,
//   the NOP encoding loaded into if_inst at reset, the PC step, the fetch
//   FSM state encoding and a word-alignment helper.
package fb_ifetch_pkg;

  localparam int FB_32BITS = 32;

  // addi x0, x0, 0
  localparam logic [FB_32BITS-1:0] FB_NOP     = 32'h0000_0013;
  localparam logic [FB_32BITS-1:0] FB_PC_STEP = 32'd4;
  localparam logic [FB_32BITS-1:0] FB_ALIGN_MASK = 32'h0000_0003;

  // IDLE  : one cycle after reset before the first request
  // REQ   : request presented, waiting for imem_ready
  // WAIT  : request accepted, waiting for imem_rvalid
  // VALID : if_pc/if_inst held for the IF/ID register
  typedef enum logic [1:0] {
    FB_IF_IDLE  = 2'd0,
    FB_IF_REQ   = 2'd1,
    FB_IF_WAIT  = 2'd2,
    FB_IF_VALID = 2'd3
  } fb_if_state_e;

  // Redirect targets may carry junk in the two low bits; fetches are
  // always word aligned.
  function automatic logic [FB_32BITS-1:0] fb_word_align(
    input logic [FB_32BITS-1:0] addr
  );
    return addr & ~FB_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fb_ifetch_pcgen.sv
// fb_ifetch_pcgen
//   Program-counter register with its next-value mux.
//   Priority: redirect target (word aligned) > sequential +4 > hold.
//   The +4 is plain 32-bit arithmetic and wraps from 32'hFFFF_FFFC to 0.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pc <= RESET_PC)
//   load_redirect   take redirect_pc this edge
//   advance         step to pc + 4 this edge (ignored when load_redirect)
//   redirect_pc     redirect target, bits [1:0] dropped
//   pc              current pc
//   pc_next         value pc takes at the next edge (used as next fetch address)
module fb_ifetch_pcgen
  import fb_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_redirect,
  input  logic                 advance,
  input  logic [FB_32BITS-1:0] redirect_pc,
  output logic [FB_32BITS-1:0] pc,
  output logic [FB_32BITS-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (load_redirect) begin
      pc_next = fb_word_align(redirect_pc);
    end else if (advance) begin
      pc_next = pc + FB_PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fb_ifetch.sv
// fb_ifetch
//   Instruction-fetch front end. Generates the sequential PC, fetches one
//   instruction at a time over a single-outstanding request/response port
//   and holds the result for the IF/ID pipeline register until it is taken.
//   Branch/jump redirects replace the PC; a response already in flight for
//   the old path is discarded via the kill flag.
//
// Handshakes:
//   imem request : a transfer happens on a posedge where imem_req = 1 and
//                  imem_ready = 1. While imem_req = 1 and imem_ready = 0,
//                  imem_req and imem_addr stay stable; a presented request
//                  is never withdrawn, even on redirect. After the transfer
//                  no new request is raised until the response returns.
//   imem response: imem_rvalid is only looked at while a request is
//                  outstanding (WAIT); at most one response per request.
//   IF/ID output : if_we = 1 marks if_pc/if_inst valid. They are consumed
//                  on a posedge with stall = 0 and held while stall = 1.
//                  A redirect drops them regardless of stall.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hazard hold (IF/ID lock)
//   redirect          taken branch/jump, one-cycle pulse
//   redirect_pc       redirect target, bits [1:0] ignored
//   imem_req/addr     fetch request and word address (registered)
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid/rdata fetch response
//   if_pc/if_inst/if_we  to the IF/ID register (registered)
//   dbg_state         current fetch FSM state (fb_if_state_e encoding)
module fb_ifetch
  import fb_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [FB_32BITS-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [FB_32BITS-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [FB_32BITS-1:0] imem_rdata,
  output logic [FB_32BITS-1:0] if_pc,
  output logic [FB_32BITS-1:0] if_inst,
  output logic                 if_we,
  output logic [1:0]           dbg_state
);

  fb_if_state_e state_q, state_d;
  logic         kill_q, kill_d;

  logic [FB_32BITS-1:0] pc_q;
  logic [FB_32BITS-1:0] pc_d;
  logic                 pc_advance;

  logic                 imem_req_d;
  logic [FB_32BITS-1:0] imem_addr_d;
  logic [FB_32BITS-1:0] if_pc_d;
  logic [FB_32BITS-1:0] if_inst_d;
  logic                 if_we_d;
  logic                 enter_req;

  // A redirect always replaces the pc, whatever the state. The pc only
  // steps forward when the held instruction is consumed.
  assign pc_advance = (state_q == FB_IF_VALID) && !stall;

  fb_ifetch_pcgen #(
    .RESET_PC (RESET_PC)
  ) u_pcgen (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_redirect (redirect),
    .advance       (pc_advance),
    .redirect_pc   (redirect_pc),
    .pc            (pc_q),
    .pc_next       (pc_d)
  );

  // ---------------------------------------------------------------------
  // State register (FSM state plus the kill flag)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FB_IF_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    unique case (state_q)
      FB_IF_IDLE: begin
        state_d = FB_IF_REQ;
      end
      FB_IF_REQ: begin
        // The presented request still completes with its old address;
        // remember to throw its response away.
        if (redirect) begin
          kill_d = 1'b1;
        end
        if (imem_ready) begin
          state_d = FB_IF_WAIT;
        end
      end
      FB_IF_WAIT: begin
        if (imem_rvalid) begin
          // A redirect arriving together with the response discards it
          // directly, so kill is never set for that case.
          kill_d  = 1'b0;
          state_d = (kill_q || redirect) ? FB_IF_REQ : FB_IF_VALID;
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      FB_IF_VALID: begin
        if (redirect || !stall) begin
          state_d = FB_IF_REQ;
        end
      end
      default: begin
        state_d = FB_IF_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------
  assign enter_req = (state_d == FB_IF_REQ) && (state_q != FB_IF_REQ);

  always_comb begin
    imem_req_d  = imem_req;
    imem_addr_d = imem_addr;
    if_pc_d     = if_pc;
    if_inst_d   = if_inst;
    if_we_d     = if_we;

    // Every new request goes out with the pc value taking effect on the
    // same edge, so a redirect or +4 is already reflected in the address.
    if (enter_req) begin
      imem_req_d  = 1'b1;
      imem_addr_d = pc_d;
    end else if ((state_q == FB_IF_REQ) && (state_d == FB_IF_WAIT)) begin
      imem_req_d  = 1'b0;
    end

    if ((state_q == FB_IF_WAIT) && (state_d == FB_IF_VALID)) begin
      if_pc_d   = pc_q;
      if_inst_d = imem_rdata;
      if_we_d   = 1'b1;
    end else if ((state_q == FB_IF_VALID) && (state_d == FB_IF_REQ)) begin
      if_we_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      if_pc     <= '0;
      if_inst   <= FB_NOP;
      if_we     <= 1'b0;
    end else begin
      imem_req  <= imem_req_d;
      imem_addr <= imem_addr_d;
      if_pc     <= if_pc_d;
      if_inst   <= if_inst_d;
      if_we     <= if_we_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_ifetch.sv
// tb_fb_ifetch
//   Bench for fb_ifetch. A memory responder returns addr ^ KEY after a
//   programmable latency. The reference model tracks the architectural PC
//   from the rules alone: reset -> RESET_PC, redirect -> aligned target,
//   consumed instruction -> +4. Each delivered if_pc must equal that PC
//   and carry the matching instruction word; each new request must use it.
//   A second instance with RESET_PC = 32'hFFFF_FFFC shares the inputs and
//   runs in lockstep to observe the +4 wrap.
module tb_fb_ifetch;
  import fb_ifetch_pkg::*;

  localparam logic [31:0] KEY        = 32'hA5A5_A5A5;
  localparam logic [31:0] W_RESET_PC = 32'hFFFF_FFFC;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imem_req, if_we;
  logic [31:0] imem_addr, if_pc, if_inst;
  logic [1:0]  dbg_state;

  logic        w_imem_req, w_if_we;
  logic [31:0] w_imem_addr, w_if_pc, w_if_inst;
  logic [1:0]  w_dbg_state;

  always #5 clk = ~clk;

  fb_ifetch dut (
    .clk (clk), .rst_n (rst_n), .stall (stall), .redirect (redirect),
    .redirect_pc (redirect_pc), .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_ready (imem_ready), .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .if_pc (if_pc), .if_inst (if_inst), .if_we (if_we), .dbg_state (dbg_state)
  );

  fb_ifetch #(.RESET_PC (W_RESET_PC)) dut_w (
    .clk (clk), .rst_n (rst_n), .stall (stall), .redirect (redirect),
    .redirect_pc (redirect_pc), .imem_req (w_imem_req), .imem_addr (w_imem_addr),
    .imem_ready (imem_ready), .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .if_pc (w_if_pc), .if_inst (w_if_inst), .if_we (w_if_we), .dbg_state (w_dbg_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard / model state
  // ---------------------------------------------------------------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] w_addr_q[$];
  logic [31:0] exp_pc = '0;
  bit          pending = 0;
  logic [31:0] pend_addr = '0;
  int          cnt = 0;
  int          lat = 1;
  bit          junk_en = 0;
  int          deliveries = 0;
  int          cyc = 0;
  bit          new_req = 0;
  bit          new_del = 0;
  bit          w_new_del = 0;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Driver: advance one clock, update model and memory, run protocol checks
  // ---------------------------------------------------------------------
  task automatic step();
    logic        p_we, p_req, p_wreq, p_wwe, i_stall, i_redir, i_ready, i_rvalid;
    logic [31:0] p_addr, p_pc, p_inst, i_rpc;
    p_we = if_we; p_req = imem_req; p_addr = imem_addr; p_pc = if_pc; p_inst = if_inst;
    p_wreq = w_imem_req; p_wwe = w_if_we;
    i_stall = stall; i_redir = redirect; i_ready = imem_ready;
    i_rvalid = imem_rvalid; i_rpc = redirect_pc;
    @(posedge clk);
    @(negedge clk);
    cyc++;

    if (i_redir) exp_pc = i_rpc & ~32'h3;
    else if (p_we && !i_stall) exp_pc = exp_pc + 32'd4;

    if (i_rvalid && pending) pending = 0;
    if (p_req && i_ready) begin
      pending = 1; pend_addr = p_addr; cnt = lat;
    end
    if (pending) begin
      cnt--;
      if (cnt <= 0) begin
        imem_rvalid = 1'b1; imem_rdata = pend_addr ^ KEY;
      end else begin
        imem_rvalid = 1'b0;
      end
    end else begin
      imem_rvalid = junk_en && ($urandom_range(0, 3) == 0);
      imem_rdata  = $urandom;
    end

    new_req = imem_req && !p_req;
    new_del = if_we && !p_we;
    w_new_del = w_if_we && !p_wwe;
    if (w_imem_req && !p_wreq) w_addr_q.push_back(w_imem_addr);

    if (new_del) begin
      deliveries++;
      total++;
      if (if_pc !== exp_pc) begin
        bad++; $display("FAIL deliver_pc: got %h want %h", if_pc, exp_pc);
      end
      total++;
      if (if_inst !== (exp_pc ^ KEY)) begin
        bad++; $display("FAIL deliver_inst: got %h want %h", if_inst, exp_pc ^ KEY);
      end
    end
    if (p_we && i_stall && !i_redir) begin
      total++;
      if (if_we !== 1'b1 || if_pc !== p_pc || if_inst !== p_inst) begin
        bad++; $display("FAIL stall_hold: got we=%b pc=%h inst=%h want we=1 pc=%h inst=%h",
                        if_we, if_pc, if_inst, p_pc, p_inst);
      end
    end
    if (p_we && (!i_stall || i_redir)) begin
      total++;
      if (if_we !== 1'b0) begin
        bad++; $display("FAIL we_drop: got %b want 0", if_we);
      end
    end
    if (p_req && !i_ready) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
        bad++; $display("FAIL req_stable: got req=%b addr=%h want req=1 addr=%h",
                        imem_req, imem_addr, p_addr);
      end
    end
    if (p_req && i_ready) begin
      total++;
      if (imem_req !== 1'b0) begin
        bad++; $display("FAIL req_release: got %b want 0", imem_req);
      end
    end
    if (new_req) begin
      total++;
      if (imem_addr !== exp_pc) begin
        bad++; $display("FAIL req_addr: got %h want %h", imem_addr, exp_pc);
      end
    end
    if (imem_req === 1'b1 && pending) begin
      total++; bad++;
      $display("FAIL outstanding: got req=1 with a response pending want req=0");
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1;
    imem_rvalid = 1'b0; pending = 0; junk_en = 0; lat = 1;
    @(negedge clk);
    rst_n = 1'b1; exp_pc = 32'h0; new_req = 0; new_del = 0; w_new_del = 0;
    w_addr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL %s_req: got %b want 0", tag, imem_req); end
    total++;
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL %s_addr: got %h want 0", tag, imem_addr); end
    total++;
    if (if_pc !== 32'h0) begin bad++; $display("FAIL %s_if_pc: got %h want 0", tag, if_pc); end
    total++;
    if (if_inst !== FB_NOP) begin bad++; $display("FAIL %s_if_inst: got %h want %h", tag, if_inst, FB_NOP); end
    total++;
    if (if_we !== 1'b0) begin bad++; $display("FAIL %s_if_we: got %b want 0", tag, if_we); end
    total++;
    if (dbg_state !== FB_IF_IDLE) begin bad++; $display("FAIL %s_state: got %0d want %0d", tag, dbg_state, FB_IF_IDLE); end
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; lat = 1; pending = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1; exp_pc = 32'h0;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    step();
    total++;
    if (if_we !== 1'b0) begin bad++; $display("FAIL early_we: got %b want 0", if_we); end
    step();
    total++;
    if (if_we !== 1'b1 || if_pc !== 32'h0 || if_inst !== KEY) begin
      bad++; $display("FAIL first_fetch: got we=%b pc=%h inst=%h want we=1 pc=0 inst=%h",
                      if_we, if_pc, if_inst, KEY);
    end
  endtask

  task automatic test_free_run();
    int last;
    exp_q.delete();
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    last = cyc;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      step();
      if (new_del) begin
        total++;
        if (if_pc !== exp_q[0]) begin bad++; $display("FAIL run_pc: got %h want %h", if_pc, exp_q[0]); end
        void'(exp_q.pop_front());
        total++;
        if (cyc - last != 3) begin bad++; $display("FAIL run_interval: got %0d want 3", cyc - last); end
        last = cyc;
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL run_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (if_we !== 1'b1 || if_pc !== 32'h8 || if_inst !== (32'h8 ^ KEY) || imem_req !== 1'b0) begin
        bad++; $display("FAIL stall_cycle: got we=%b pc=%h inst=%h req=%b want we=1 pc=8 inst=%h req=0",
                        if_we, if_pc, if_inst, imem_req, 32'h8 ^ KEY);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC || if_we !== 1'b0) begin
      bad++; $display("FAIL stall_release: got req=%b addr=%h we=%b want req=1 addr=c we=0",
                      imem_req, imem_addr, if_we);
    end
  endtask

  task automatic test_redirect_wait();
    int d0;
    apply_reset();
    lat = 3;
    for (int i = 0; i < 30 && !(pending && pend_addr == 32'h4); i++) step();
    total++;
    if (!(pending && pend_addr == 32'h4)) begin
      bad++; $display("FAIL rw_reach: got pending=%b addr=%h want pending=1 addr=4", pending, pend_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h100;
    d0 = deliveries;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 20 && !new_req; i++) step();
    total++;
    if (!new_req || imem_addr !== 32'h100) begin
      bad++; $display("FAIL rw_next_addr: got req=%b addr=%h want req=1 addr=100", new_req, imem_addr);
    end
    total++;
    if (deliveries != d0) begin bad++; $display("FAIL rw_dropped: got %0d deliveries want 0", deliveries - d0); end
    lat = 1;
    for (int i = 0; i < 20 && !new_del; i++) step();
    total++;
    if (!new_del || if_pc !== 32'h100) begin
      bad++; $display("FAIL rw_deliver: got we=%b pc=%h want we=1 pc=100", if_we, if_pc);
    end
  endtask

  task automatic test_redirect_rvalid();
    int d0;
    for (int i = 0; i < 20 && imem_rvalid !== 1'b1; i++) step();
    total++;
    if (imem_rvalid !== 1'b1) begin bad++; $display("FAIL rr_reach: got rvalid=%b want 1", imem_rvalid); end
    redirect = 1'b1; redirect_pc = 32'h203;
    d0 = deliveries;
    step();
    redirect = 1'b0;
    total++;
    if (if_we !== 1'b0 || deliveries != d0) begin
      bad++; $display("FAIL rr_no_we: got we=%b want 0", if_we);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL rr_next_addr: got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr);
    end
  endtask

  task automatic test_ready_low();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
        bad++; $display("FAIL ready_low: got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr);
      end
    end
    imem_ready = 1'b1;
    for (int i = 0; i < 20 && !new_del; i++) step();
    total++;
    if (!new_del || if_pc !== 32'h200 || if_inst !== (32'h200 ^ KEY)) begin
      bad++; $display("FAIL ready_deliver: got pc=%h inst=%h want pc=200 inst=%h", if_pc, if_inst, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w_first_pc;
    w_first_pc = 32'h1;
    apply_reset();
    for (int i = 0; i < 30 && w_addr_q.size() < 2; i++) begin
      step();
      if (w_new_del) w_first_pc = w_if_pc;
      total++;
      if (w_dbg_state !== dbg_state || w_imem_req !== imem_req || w_if_we !== if_we) begin
        bad++; $display("FAIL wrap_lockstep: got state=%0d req=%b we=%b want state=%0d req=%b we=%b",
                        w_dbg_state, w_imem_req, w_if_we, dbg_state, imem_req, if_we);
      end
    end
    total++;
    if (w_addr_q.size() < 2) begin
      bad++; $display("FAIL wrap_reach: got %0d requests want 2", w_addr_q.size());
    end else begin
      total++;
      if (w_addr_q[0] !== W_RESET_PC) begin bad++; $display("FAIL wrap_first: got %h want %h", w_addr_q[0], W_RESET_PC); end
      total++;
      if (w_addr_q[1] !== 32'h0) begin bad++; $display("FAIL wrap_second: got %h want 0", w_addr_q[1]); end
    end
    total++;
    if (w_first_pc !== W_RESET_PC) begin bad++; $display("FAIL wrap_if_pc: got %h want %h", w_first_pc, W_RESET_PC); end
  endtask

  task automatic test_async_reset();
    stall = 1'b0;
    for (int i = 0; i < 20 && !new_del; i++) step();
    stall = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    pending = 0; stall = 1'b0; exp_pc = 32'h0;
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_we !== 1'b0) begin
      bad++; $display("FAIL async_restart: got req=%b addr=%h we=%b want req=1 addr=0 we=0",
                      imem_req, imem_addr, if_we);
    end
    for (int i = 0; i < 20 && !new_del; i++) step();
    total++;
    if (!new_del || if_pc !== 32'h0 || if_inst !== KEY) begin
      bad++; $display("FAIL async_deliver: got pc=%h inst=%h want pc=0 inst=%h", if_pc, if_inst, KEY);
    end
  endtask

  task automatic test_random();
    int d0, last, max_gap;
    junk_en = 1;
    d0 = deliveries;
    last = cyc;
    max_gap = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_ready  = ($urandom_range(0, 2) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 23) == 0);
      redirect_pc = $urandom;
      lat         = $urandom_range(1, 4);
      step();
      if (new_del) last = cyc;
      if (cyc - last > max_gap) max_gap = cyc - last;
      if (max_gap > 200) break;
    end
    redirect = 1'b0; stall = 1'b0; junk_en = 0; lat = 1;
    total++;
    if (max_gap > 200) begin bad++; $display("FAIL random_progress: got gap %0d want <= 200", max_gap); end
    total++;
    if (deliveries - d0 < 50) begin bad++; $display("FAIL random_count: got %0d want >= 50", deliveries - d0); end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------
  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_ready_low();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_ifetch.md
# fb_ifetch

Instruction-fetch front end that produces the `if_pc`/`if_inst` pair and its write enable for the IF/ID pipeline register. It generates the sequential PC, fetches each instruction over a single-outstanding request/response instruction-memory port and holds the result until the IF/ID register accepts it. It also accepts branch/jump redirects from later stages, discarding any in-flight wrong-path response.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `stall`  in  1  hazard hold; same signal that drives the IF/ID register `lock`.
- `redirect`  in  1  branch/jump taken; single-cycle pulse.
- `redirect_pc`  in  `FB_32BITS`  redirect target; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  `FB_32BITS`  fetch address; word aligned.
- `imem_ready`  in  1  memory accepts the request in this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  `FB_32BITS`  instruction word.
- `if_pc`  out  `FB_32BITS`  to IF/ID register `if_pc`.
- `if_inst`  out  `FB_32BITS`  to IF/ID register `if_inst`.
- `if_we`  out  1  to IF/ID register `we`; high while `if_pc`/`if_inst` are valid.

## Operation
- Internal registers: `pc`, state, and `kill` flag. All outputs are registered.
- Reset values:
  - state IDLE, `pc` = `RESET_PC`, `kill` = 0
  - `imem_req` = 0, `imem_addr` = 0
  - `if_pc` = 0, `if_inst` = 32'h0000_0013 (NOP), `if_we` = 0
- States and transitions:
  - IDLE: next edge goes to REQ; `imem_req` becomes 1 and `imem_addr` = `pc`.
  - REQ: `imem_req` and `imem_addr` are held stable until `imem_ready` = 1 at a posedge. Then go to WAIT with `imem_req` = 0.
  - WAIT: wait for `imem_rvalid`.
    - If `kill` = 1 or `redirect` = 1: discard the response, clear `kill`, and go to REQ with `imem_addr` = `pc`.
    - Otherwise: `if_pc` ← `pc`, `if_inst` ← `imem_rdata`, `if_we` ← 1, go to VALID.
  - VALID: the output is consumed at a posedge with `stall` = 0. Then `if_we` ← 0, `pc` ← `pc` + 4, go to REQ with the new address. While `stall` = 1, all outputs and state are held.
- Redirect handling (redirect has priority over stall):
  - IDLE: `pc` ← `redirect_pc`.
  - REQ (including same cycle as `imem_ready`): `pc` ← `redirect_pc`, `kill` ← 1. The already-presented request completes with its old address; it is never retracted.
  - WAIT without `rvalid`: `pc` ← `redirect_pc`, `kill` ← 1.
  - WAIT with `rvalid`: response discarded, `pc` ← `redirect_pc`, go to REQ; `kill` stays 0.
  - VALID: `if_we` ← 0, `pc` ← `redirect_pc`, go to REQ.
  - If the IF/ID register captures on that same edge, flushing it is the ID stage's responsibility.
- Arithmetic: `pc` + 4 is 32-bit and wraps 32'hFFFF_FFFC → 0.
- `imem_rvalid` outside WAIT is ignored. At most one request is outstanding.

## Timing
- Posedge-registered throughout. The IF/ID register samples `if_we`/`if_pc`/`if_inst` on the same posedge at which VALID→REQ occurs.
- With `imem_ready` = 1 at first REQ and `imem_rvalid` one cycle later:
  - reset release → `imem_req` high after 1 edge;
  - `if_we` high 3 edges after release.
- Steady-state throughput without stall: one instruction per 3 cycles (REQ, WAIT, VALID).
- `rst_n` asserted mid-operation clears everything immediately. A response arriving after reset deasserts while in IDLE is ignored.

## Structure
- `FB_32BITS`, the NOP encoding (`FB_NOP`), and state encodings (`FB_IF_IDLE/REQ/WAIT/VALID`) belong in the shared `fb_defines.v`.
- Single flat module. Optionally, `fb_pcgen` (pc register with +4/redirect mux) is a natural sub-module.

## Test plan
- Reset then free run, memory returns `rdata` = addr ^ 32'hA5A5_A5A5 with ready = 1 and 1-cycle rvalid → `if_pc` sequence 0, 4, 8 with matching `if_inst`, `if_we` pulsing every 3 cycles.
- `stall` held 5 cycles in VALID at `pc` = 8 → `if_we`, `if_pc`, `if_inst` unchanged for 5 cycles; next `imem_addr` = 12 only after `stall` drops.
- `redirect` to 32'h100 while in WAIT for addr 4 → that response is dropped (`if_we` stays 0); next `imem_addr` = 32'h100, then `if_pc` = 32'h100.
- `redirect` to 32'h203 in the same cycle as `imem_rvalid` → no `if_we`; next `imem_addr` = 32'h200.
- `imem_ready` held low 4 cycles → `imem_req`/`imem_addr` stable throughout. `RESET_PC` = 32'hFFFF_FFFC → second fetch address 0 (wrap).
- `rst_n` pulsed low while in VALID with stall → all outputs return to reset values asynchronously; next fetch is at `RESET_PC`.
